// File: rtl/i2c_codec_config_pkg.sv
// Shared types, WM8731 register map and frame builder
// for the codec configuration sequencer.
package i2c_codec_config_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_INIT  = 3'd1;
  localparam state_t S_LOAD  = 3'd2;
  localparam state_t S_XFER  = 3'd3;
  localparam state_t S_CHECK = 3'd4;
  localparam state_t S_GAP   = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  localparam state_t S_ERROR = 3'd7;

  localparam logic [6:0] R_LINVOL = 7'd0;
  localparam logic [6:0] R_RINVOL = 7'd1;
  localparam logic [6:0] R_LHPOUT = 7'd2;
  localparam logic [6:0] R_RHPOUT = 7'd3;
  localparam logic [6:0] R_APANA  = 7'd4;
  localparam logic [6:0] R_DPATH  = 7'd5;
  localparam logic [6:0] R_PWR    = 7'd6;
  localparam logic [6:0] R_IFACE  = 7'd7;
  localparam logic [6:0] R_SRATE  = 7'd8;
  localparam logic [6:0] R_ACTIVE = 7'd9;
  localparam logic [6:0] R_RESET  = 7'd15;

  function automatic logic [15:0] entry(
    input logic [6:0] a,
    input logic [8:0] d
  );
    return {a, d};
  endfunction

  // Ack slots are 1 so the engine releases SDA.
  function automatic logic [26:0] build_frame(
    input logic [7:0]  dev,
    input logic [15:0] e
  );
    return {dev, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/i2c_codec_config_if.sv
// Sequencer <-> engine/top-level signal bundle.
// master = sequencer side, slave = engine/top side.
interface i2c_codec_config_if;
  logic        start;
  logic        ACK;
  logic [26:0] regdata;
  logic        GO;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  reg_index;

  modport master (
    input  start, ACK,
    output regdata, GO, busy, done, error, reg_index
  );

  modport slave (
    output start, ACK,
    input  regdata, GO, busy, done, error, reg_index
  );
endinterface

// File: rtl/i2c_codec_config_codec_reg_rom.sv
// Default WM8731 setting table, index -> {addr, data}.
// Entries at or beyond NUM_REGS read as zero.
module codec_reg_rom
  import i2c_codec_config_pkg::*;
#(
  parameter int NUM_REGS = 11
) (
  input  logic [3:0]  idx_i,
  output logic [15:0] entry_o
);

  localparam logic [4:0] NR = 5'(NUM_REGS);

  logic [15:0] raw;

  always_comb begin
    raw = 16'h0000;
    case (idx_i)
      4'd0:    raw = entry(R_RESET,  9'h000);
      4'd1:    raw = entry(R_LINVOL, 9'h017);
      4'd2:    raw = entry(R_RINVOL, 9'h017);
      4'd3:    raw = entry(R_LHPOUT, 9'h079);
      4'd4:    raw = entry(R_RHPOUT, 9'h079);
      4'd5:    raw = entry(R_APANA,  9'h012);
      4'd6:    raw = entry(R_DPATH,  9'h000);
      4'd7:    raw = entry(R_PWR,    9'h000);
      4'd8:    raw = entry(R_IFACE,  9'h042);
      4'd9:    raw = entry(R_SRATE,  9'h000);
      4'd10:   raw = entry(R_ACTIVE, 9'h001);
      default: raw = 16'h0000;
    endcase
    entry_o = ({1'b0, idx_i} < NR) ? raw : 16'h0000;
  end

endmodule

// File: rtl/i2c_codec_config.sv
// Codec configuration sequencer: walks the ROM,
// drives GO windows to the I2C engine, retries NACKs.
module i2c_codec_config
  import i2c_codec_config_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 11,
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int unsigned INIT_DELAY  = 1000,
  parameter int unsigned XFER_CYCLES = 64,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic            CLK,
  input  logic            reset,
  i2c_codec_config_if.master bus
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_DELAY - 1);
  localparam logic [15:0] XFER_LAST = 16'(XFER_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [3:0]  IDX_LAST  = 4'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic [3:0]  idx_q, idx_d;
  logic        adv_q, adv_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [26:0] regdata_q, regdata_d;
  logic        start_q;
  logic [15:0] rom_entry;

  codec_reg_rom #(
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      adv_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      regdata_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      adv_q     <= adv_d;
      done_q    <= done_d;
      error_q   <= error_d;
      regdata_q <= regdata_d;
      start_q   <= bus.start;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    adv_d     = adv_q;
    done_d    = done_q;
    error_d   = error_q;
    regdata_d = regdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !start_q) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
          adv_d   = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        regdata_d = build_frame(DEV_ADDR, rom_entry);
        state_d   = S_XFER;
        cnt_d     = '0;
      end
      S_XFER: begin
        if (cnt_q == XFER_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = S_GAP;
        if (!bus.ACK) begin
          adv_d = 1'b1;
        end else if (retry_q != RETRY_MAX) begin
          adv_d   = 1'b0;
          retry_d = retry_q + 2'd1;
        end else begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!adv_q) begin
            state_d = S_LOAD;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            retry_d = '0;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.GO        = (state_q == S_XFER);
    bus.busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    bus.regdata   = regdata_q;
    bus.done      = done_q;
    bus.error     = error_q;
    bus.reg_index = idx_q;
  end

endmodule

// File: tb/tb_i2c_codec_config.sv
// Bench for i2c_codec_config: directed + random NACK
// patterns against a frame-list reference model.
module tb_i2c_codec_config;

  localparam int NREG = 11;
  localparam int INIT = 10;
  localparam int XFER = 64;
  localparam int GAP  = 8;
  localparam int MAXR = 3;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  i2c_codec_config_if bus();

  i2c_codec_config #(
    .NUM_REGS    (NREG),
    .DEV_ADDR    (8'h34),
    .INIT_DELAY  (INIT),
    .XFER_CYCLES (XFER),
    .GAP_CYCLES  (GAP),
    .MAX_RETRY   (MAXR)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] tbl [NREG];
  int          nk  [NREG];
  logic [26:0] exp_rd [$];
  bit          exp_ack [$];
  bit          exp_done, exp_err;
  int          exp_idx;
  logic [26:0] obs [$];

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [26:0] frm(input logic [15:0] e);
    return {8'h34, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
  endfunction

  // Each entry is sent until acked, at most MAXR+1 times.
  task automatic model();
    int sends;
    exp_rd.delete();
    exp_ack.delete();
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_idx  = NREG - 1;
    for (int i = 0; i < NREG; i++) begin
      sends = (nk[i] > MAXR) ? MAXR + 1 : nk[i] + 1;
      for (int s = 0; s < sends; s++) begin
        exp_rd.push_back(frm(tbl[i]));
        exp_ack.push_back(s < nk[i]);
      end
      if (nk[i] > MAXR) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_idx  = i;
        break;
      end
    end
  endtask

  task automatic run(input bit hold, input bit repulse,
                     input string tag);
    int cyc, wlen, gap, first_go, tail, k, n;
    bit go_p, stable, fin;
    logic [26:0] rd;
    obs.delete();
    cyc = 0; wlen = 0; gap = 0; first_go = -1;
    tail = 0; go_p = 0; stable = 1; fin = 0; rd = '0;
    @(negedge CLK);
    bus.start = 1'b1;
    while (cyc < 6000 && tail < 150) begin
      @(negedge CLK);
      cyc++;
      if (!hold) bus.start = 1'b0;
      if (bus.GO && !go_p) begin
        if (first_go < 0) first_go = cyc;
        else chk({tag, ":gap"}, gap, GAP + 2);
        obs.push_back(bus.regdata);
        rd = bus.regdata;
        wlen = 1;
        stable = 1;
        k = obs.size() - 1;
        bus.ACK = (k < exp_ack.size()) ? exp_ack[k] : 1'b0;
        if (repulse && k == 2) bus.start = 1'b1;
      end else if (bus.GO) begin
        wlen++;
        if (bus.regdata !== rd) stable = 0;
      end else if (go_p) begin
        chk({tag, ":win"}, wlen, XFER);
        chk({tag, ":stable"}, 32'(stable), 1);
        gap = 1;
      end else begin
        gap++;
      end
      go_p = bus.GO;
      if (fin) tail++;
      else if (bus.done || bus.error) begin
        fin = 1;
        chk({tag, ":busy_end"}, 32'(bus.busy), 0);
      end
    end
    chk({tag, ":finished"}, 32'(fin), 1);
    chk({tag, ":latency"}, first_go, INIT + 2);
    chk({tag, ":nframes"}, obs.size(), exp_rd.size());
    n = (obs.size() < exp_rd.size()) ? obs.size()
                                     : exp_rd.size();
    for (int j = 0; j < n; j++)
      chk($sformatf("%s:frame%0d", tag, j), obs[j], exp_rd[j]);
    chk({tag, ":done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, ":error"}, 32'(bus.error), 32'(exp_err));
    chk({tag, ":index"}, 32'(bus.reg_index), exp_idx);
    bus.start = 1'b0;
    bus.ACK   = 1'b0;
  endtask

  task automatic clear_nk();
    for (int i = 0; i < NREG; i++) nk[i] = 0;
  endtask

  initial begin
    int gos, budget;
    bit go_p;
    tbl[0]  = {7'd15, 9'h000};
    tbl[1]  = {7'd0,  9'h017};
    tbl[2]  = {7'd1,  9'h017};
    tbl[3]  = {7'd2,  9'h079};
    tbl[4]  = {7'd3,  9'h079};
    tbl[5]  = {7'd4,  9'h012};
    tbl[6]  = {7'd5,  9'h000};
    tbl[7]  = {7'd6,  9'h000};
    tbl[8]  = {7'd7,  9'h042};
    tbl[9]  = {7'd8,  9'h000};
    tbl[10] = {7'd9,  9'h001};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst:GO", 32'(bus.GO), 0);
    chk("rst:busy", 32'(bus.busy), 0);
    chk("rst:done", 32'(bus.done), 0);
    chk("rst:error", 32'(bus.error), 0);
    chk("rst:index", 32'(bus.reg_index), 0);
    chk("rst:regdata", 32'(bus.regdata), 0);
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    clear_nk();
    model();
    run(0, 0, "seq");
    chk("frame_apana", (obs.size() > 5) ? obs[5] : 27'd0,
        {8'h34, 1'b1, 8'h08, 1'b1, 8'h12, 1'b1});

    clear_nk();
    nk[3] = 1;
    model();
    run(0, 1, "nack3");
    chk("nack3:same", (obs.size() > 4) ? obs[4] : 27'd0,
        (obs.size() > 3) ? obs[3] : 27'h1);

    clear_nk();
    nk[5] = 9;
    model();
    run(0, 0, "stuck5");

    clear_nk();
    model();
    run(1, 0, "hold");

    // Abort entry 2 mid-window with an async reset.
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    gos = 0; budget = 0; go_p = 0;
    while (gos < 3 && budget < 4000) begin
      @(negedge CLK);
      budget++;
      if (bus.GO && !go_p) gos++;
      go_p = bus.GO;
    end
    chk("rstmid:reached", gos, 3);
    repeat (5) @(negedge CLK);
    chk("rstmid:GO_before", 32'(bus.GO), 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid:GO", 32'(bus.GO), 0);
    chk("rstmid:busy", 32'(bus.busy), 0);
    chk("rstmid:index", 32'(bus.reg_index), 0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (20) @(negedge CLK);
    chk("rstmid:idle_GO", 32'(bus.GO), 0);
    model();
    run(0, 0, "after_rst");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++)
        nk[i] = ($urandom_range(0, 6) == 0)
                ? int'($urandom_range(1, 5)) : 0;
      model();
      run(0, 0, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
